// File: rtl/lpddr2_avl_arbiter.sv
// Two-requester round-robin arbiter in front of the LPDDR2 controller avl_0 port, with calibration gating
// and in-order read response routing. Define ARB_PERF_CNT_EN to add command and stall counters.
module lpddr2_avl_arbiter #(
   parameter int TAG_DEPTH = 8,
   parameter int ADDR_W    = 27,
   parameter int DATA_W    = 32
) (
   input  logic                  clk_clk,
   input  logic                  reset_reset,
   input  logic [ADDR_W-1:0]     m0_address,
   input  logic [ADDR_W-1:0]     m1_address,
   input  logic [DATA_W-1:0]     m0_writedata,
   input  logic [DATA_W-1:0]     m1_writedata,
   input  logic [DATA_W/8-1:0]   m0_byteenable,
   input  logic [DATA_W/8-1:0]   m1_byteenable,
   input  logic                  m0_read,
   input  logic                  m1_read,
   input  logic                  m0_write,
   input  logic                  m1_write,
   output logic                  m0_waitrequest_n,
   output logic                  m1_waitrequest_n,
   output logic [DATA_W-1:0]     m0_readdata,
   output logic [DATA_W-1:0]     m1_readdata,
   output logic                  m0_readdatavalid,
   output logic                  m1_readdatavalid,
   output logic [ADDR_W-1:0]     mem_address,
   output logic [DATA_W-1:0]     mem_writedata,
   output logic [DATA_W/8-1:0]   mem_byteenable,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic                  mem_burstcount,
   output logic                  mem_beginbursttransfer,
   input  logic                  mem_waitrequest_n,
   input  logic [DATA_W-1:0]     mem_readdata,
   input  logic                  mem_readdatavalid,
   input  logic                  local_init_done,
   input  logic                  local_cal_success,
   input  logic                  local_cal_fail,
   output logic                  arb_ready,
   output logic                  cal_error,
   output logic                  rsp_error
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [31:0]           m0_cmd_count,
   output logic [31:0]           m1_cmd_count,
   output logic [31:0]           stall_count
`endif
);

   localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {WAIT_CAL, READY, FAIL} state_t;

   state_t               state;
   logic                 grant;
   logic                 stalled;
   logic [TAG_DEPTH-1:0] tag_id;
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [CNT_W-1:0]     tag_count;

   logic tag_full, tag_empty;
   logic m0_elig, m1_elig, other_elig;
   logic sel_wr, sel_rd;
   logic cmd_valid, accept, push, pop;

   // Full is judged on the registered count, so a pop in the same cycle cannot admit a read
   assign tag_full  = (tag_count == CNT_W'(TAG_DEPTH));
   assign tag_empty = (tag_count == '0);

   assign m0_elig    = m0_write | (m0_read & ~tag_full);
   assign m1_elig    = m1_write | (m1_read & ~tag_full);
   assign other_elig = grant ? m0_elig : m1_elig;

   assign sel_wr = grant ? m1_write : m0_write;
   assign sel_rd = grant ? (m1_read & ~m1_write) : (m0_read & ~m0_write);

   assign mem_write = arb_ready & sel_wr;
   assign mem_read  = arb_ready & sel_rd & ~tag_full;
   assign cmd_valid = mem_read | mem_write;
   assign accept    = cmd_valid & mem_waitrequest_n;

   assign mem_address    = cmd_valid ? (grant ? m1_address    : m0_address)    : '0;
   assign mem_writedata  = cmd_valid ? (grant ? m1_writedata  : m0_writedata)  : '0;
   assign mem_byteenable = cmd_valid ? (grant ? m1_byteenable : m0_byteenable) : '0;
   assign mem_burstcount = 1'b1;
   assign mem_beginbursttransfer = cmd_valid & ~stalled;

   assign m0_waitrequest_n = accept & ~grant;
   assign m1_waitrequest_n = accept & grant;

   assign push = accept & mem_read;
   assign pop  = mem_readdatavalid & ~tag_empty;

   assign m0_readdata      = mem_readdata;
   assign m1_readdata      = mem_readdata;
   assign m0_readdatavalid = pop & ~tag_id[rd_ptr];
   assign m1_readdatavalid = pop & tag_id[rd_ptr];

   // Calibration FSM: one-way into READY or FAIL, failure wins a tie
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         state     <= WAIT_CAL;
         arb_ready <= 1'b0;
         cal_error <= 1'b0;
      end else begin
         case (state)
            WAIT_CAL: begin
               if (local_cal_fail) begin
                  state     <= FAIL;
                  cal_error <= 1'b1;
               end else if (local_init_done & local_cal_success) begin
                  state     <= READY;
                  arb_ready <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Grant holds through a stalled command, hands over after each accept, and skips an idle owner
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         grant   <= 1'b0;
         stalled <= 1'b0;
      end else begin
         stalled <= cmd_valid & ~mem_waitrequest_n;
         if (arb_ready) begin
            if (accept) begin
               if (other_elig) grant <= ~grant;
            end else if (!cmd_valid && other_elig) begin
               grant <= ~grant;
            end
         end
      end
   end

   // In-order tag FIFO recording which requester owns each outstanding read
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         tag_id    <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         tag_count <= '0;
         rsp_error <= 1'b0;
      end else begin
         if (push) begin
            tag_id[wr_ptr] <= grant;
            wr_ptr         <= wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   tag_count <= tag_count + CNT_W'(1);
            2'b01:   tag_count <= tag_count - CNT_W'(1);
            default: ;
         endcase
         if (mem_readdatavalid && tag_empty && arb_ready) rsp_error <= 1'b1;
      end
   end

`ifdef ARB_PERF_CNT_EN
   // Free-running wrap-around counters of accepted commands and of blocked READY cycles
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         m0_cmd_count <= '0;
         m1_cmd_count <= '0;
         stall_count  <= '0;
      end else begin
         if (accept && !grant) m0_cmd_count <= m0_cmd_count + 32'd1;
         if (accept && grant)  m1_cmd_count <= m1_cmd_count + 32'd1;
         if (arb_ready && (m0_read | m0_write | m1_read | m1_write) && !accept)
            stall_count <= stall_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_lpddr2_avl_arbiter.sv
// Self-checking bench for lpddr2_avl_arbiter: directed calibration/fairness/tag-FIFO scenarios plus a
// randomized run checked against a queue-based model of outstanding read owners.
module tb_lpddr2_avl_arbiter;

   localparam int TAG_DEPTH = 8;
   localparam int ADDR_W    = 27;
   localparam int DATA_W    = 32;
   localparam int BE_W      = DATA_W / 8;

   logic              clk_clk = 1'b0;
   logic              reset_reset;
   logic [ADDR_W-1:0] m0_address, m1_address;
   logic [DATA_W-1:0] m0_writedata, m1_writedata;
   logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
   logic              m0_read, m1_read, m0_write, m1_write;
   logic              m0_waitrequest_n, m1_waitrequest_n;
   logic [DATA_W-1:0] m0_readdata, m1_readdata;
   logic              m0_readdatavalid, m1_readdatavalid;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_writedata;
   logic [BE_W-1:0]   mem_byteenable;
   logic              mem_read, mem_write, mem_burstcount, mem_beginbursttransfer;
   logic              mem_waitrequest_n;
   logic [DATA_W-1:0] mem_readdata;
   logic              mem_readdatavalid;
   logic              local_init_done, local_cal_success, local_cal_fail;
   logic              arb_ready, cal_error, rsp_error;
`ifdef ARB_PERF_CNT_EN
   logic [31:0]       m0_cmd_count, m1_cmd_count, stall_count;
`endif

   lpddr2_avl_arbiter #(.TAG_DEPTH(TAG_DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk_clk(clk_clk), .reset_reset(reset_reset),
      .m0_address(m0_address), .m1_address(m1_address),
      .m0_writedata(m0_writedata), .m1_writedata(m1_writedata),
      .m0_byteenable(m0_byteenable), .m1_byteenable(m1_byteenable),
      .m0_read(m0_read), .m1_read(m1_read), .m0_write(m0_write), .m1_write(m1_write),
      .m0_waitrequest_n(m0_waitrequest_n), .m1_waitrequest_n(m1_waitrequest_n),
      .m0_readdata(m0_readdata), .m1_readdata(m1_readdata),
      .m0_readdatavalid(m0_readdatavalid), .m1_readdatavalid(m1_readdatavalid),
      .mem_address(mem_address), .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
      .mem_read(mem_read), .mem_write(mem_write), .mem_burstcount(mem_burstcount),
      .mem_beginbursttransfer(mem_beginbursttransfer), .mem_waitrequest_n(mem_waitrequest_n),
      .mem_readdata(mem_readdata), .mem_readdatavalid(mem_readdatavalid),
      .local_init_done(local_init_done), .local_cal_success(local_cal_success),
      .local_cal_fail(local_cal_fail),
      .arb_ready(arb_ready), .cal_error(cal_error), .rsp_error(rsp_error)
`ifdef ARB_PERF_CNT_EN
      , .m0_cmd_count(m0_cmd_count), .m1_cmd_count(m1_cmd_count), .stall_count(stall_count)
`endif
   );

   always #5 clk_clk = ~clk_clk;

   int pass_count  = 0;
   int check_count = 0;

   // Owner (0/1) of every read the controller has accepted but not yet answered, oldest first
   int exp_ids[$];

   int                acc_id;
   logic              prev_stall;
   logic              s_ready, s_read, s_write, s_begin, s_m0_rdv, s_m1_rdv;
   logic [ADDR_W-1:0] s_addr;
   logic [DATA_W-1:0] s_m0_data, s_m1_data;

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      check_count++;
      if (actual === expected) pass_count++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
   endtask

   task automatic applyStimulus(input int id, input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] data, input logic [BE_W-1:0] be);
      if (id == 0) begin
         m0_read = rd; m0_write = wr; m0_address = addr; m0_writedata = data; m0_byteenable = be;
      end else begin
         m1_read = rd; m1_write = wr; m1_address = addr; m1_writedata = data; m1_byteenable = be;
      end
   endtask

   // Checks made every cycle against the model, sampled mid-cycle
   task automatic observeCycle();
      int id;
      acc_id = -1;
      if (exp_ids.size() >= TAG_DEPTH) checkOutput("full_no_read", mem_read, 1'b0);
      checkOutput("accept_ack", m0_waitrequest_n | m1_waitrequest_n,
                  (mem_read | mem_write) & mem_waitrequest_n);
      checkOutput("begin_burst", mem_beginbursttransfer, (mem_read | mem_write) & ~prev_stall);
      prev_stall = (mem_read | mem_write) & ~mem_waitrequest_n;
      if (mem_readdatavalid) begin
         if (exp_ids.size() > 0) begin
            id = exp_ids.pop_front();
            checkOutput("rdv_m0", m0_readdatavalid, id == 0);
            checkOutput("rdv_m1", m1_readdatavalid, id == 1);
            checkOutput("rdata", (id == 1) ? m1_readdata : m0_readdata, mem_readdata);
         end else begin
            checkOutput("orphan_rdv", {m0_readdatavalid, m1_readdatavalid}, 2'b00);
         end
      end else begin
         checkOutput("idle_rdv", {m0_readdatavalid, m1_readdatavalid}, 2'b00);
      end
      if (m0_waitrequest_n | m1_waitrequest_n) begin
         checkOutput("one_ack", m0_waitrequest_n & m1_waitrequest_n, 1'b0);
         id = m1_waitrequest_n ? 1 : 0;
         checkOutput("acc_addr", mem_address, (id == 1) ? m1_address : m0_address);
         checkOutput("acc_be", mem_byteenable, (id == 1) ? m1_byteenable : m0_byteenable);
         checkOutput("acc_wr", mem_write, (id == 1) ? m1_write : m0_write);
         checkOutput("acc_rd", mem_read, (id == 1) ? (m1_read & ~m1_write) : (m0_read & ~m0_write));
         if (mem_write) checkOutput("acc_wdata", mem_writedata, (id == 1) ? m1_writedata : m0_writedata);
         if (mem_read) exp_ids.push_back(id);
         acc_id = id;
      end
      s_ready = arb_ready; s_read = mem_read; s_write = mem_write; s_begin = mem_beginbursttransfer;
      s_addr = mem_address; s_m0_rdv = m0_readdatavalid; s_m1_rdv = m1_readdatavalid;
      s_m0_data = m0_readdata; s_m1_data = m1_readdata;
   endtask

   task automatic endCycle();
      @(negedge clk_clk);
      observeCycle();
      @(posedge clk_clk);
      #1;
   endtask

   task automatic issueCmd(input int id, input logic rd, input logic [ADDR_W-1:0] addr);
      int got = 0;
      applyStimulus(id, rd, ~rd, addr, 32'h0, 4'hF);
      for (int t = 0; t < 20 && got == 0; t++) begin
         endCycle();
         if (acc_id == id) begin
            got = 1;
            checkOutput("issue_addr", s_addr, addr);
         end
      end
      checkOutput("issue_accepted", got, 1);
      applyStimulus(id, 1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic respond(input logic [DATA_W-1:0] data);
      mem_readdatavalid = 1'b1;
      mem_readdata      = data;
      endCycle();
      mem_readdatavalid = 1'b0;
      mem_readdata      = '0;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int bad, n, m1_acc, blocked, got, kind, max_age;
      int act[2];
      int age[2];

      reset_reset = 1'b1;
      applyStimulus(0, 1'b0, 1'b0, '0, '0, '0);
      applyStimulus(1, 1'b0, 1'b0, '0, '0, '0);
      mem_waitrequest_n = 1'b0; mem_readdata = '0; mem_readdatavalid = 1'b0;
      local_init_done = 1'b0; local_cal_success = 1'b0; local_cal_fail = 1'b0;
      prev_stall = 1'b0;
      #2;
      checkOutput("rst_arb_ready", arb_ready, 1'b0);
      checkOutput("rst_cal_error", cal_error, 1'b0);
      checkOutput("rst_rsp_error", rsp_error, 1'b0);
      checkOutput("rst_mem_cmd", {mem_read, mem_write, mem_beginbursttransfer}, 3'b000);
      checkOutput("rst_burstcount", mem_burstcount, 1'b1);
      checkOutput("rst_ack", {m0_waitrequest_n, m1_waitrequest_n}, 2'b00);
      checkOutput("rst_mem_addr", mem_address, '0);
      @(posedge clk_clk); #1;
      reset_reset = 1'b0;

      $display("[TB] calibration gating");
      local_init_done = 1'b1; mem_waitrequest_n = 1'b1;
      applyStimulus(0, 1'b0, 1'b1, 27'h111, 32'hCAFE0001, 4'hF);
      bad = 0;
      for (int c = 0; c < 50; c++) begin
         endCycle();
         if (s_ready || s_write || s_read || acc_id >= 0) bad++;
      end
      checkOutput("calwait_quiet", bad, 0);
      local_cal_success = 1'b1;
      endCycle();
      checkOutput("ready_not_yet", s_ready, 1'b0);
      endCycle();
      checkOutput("ready_set", s_ready, 1'b1);
      checkOutput("first_write", s_write, 1'b1);
      checkOutput("first_begin", s_begin, 1'b1);
      checkOutput("first_addr", s_addr, 27'h111);
      checkOutput("first_acc", acc_id, 0);
      applyStimulus(0, 1'b0, 1'b0, '0, '0, '0);

      $display("[TB] round-robin alternation");
      applyStimulus(0, 1'b0, 1'b1, 27'h0A0, 32'h0000_00A0, 4'h3);
      applyStimulus(1, 1'b0, 1'b1, 27'h0B0, 32'h0000_00B0, 4'hC);
      for (int c = 0; c < 10; c++) begin
         endCycle();
         checkOutput("alt_owner", acc_id, c % 2);
         checkOutput("alt_addr", s_addr, (c % 2 == 1) ? 27'h0B0 : 27'h0A0);
      end
      applyStimulus(0, 1'b0, 1'b0, '0, '0, '0);
      applyStimulus(1, 1'b0, 1'b0, '0, '0, '0);
      endCycle();

      $display("[TB] tag FIFO full");
      n = 0;
      applyStimulus(0, 1'b1, 1'b0, 27'h200, '0, 4'hF);
      for (int t = 0; t < 40 && n < TAG_DEPTH; t++) begin
         endCycle();
         if (acc_id == 0) begin
            n++;
            applyStimulus(0, 1'b1, 1'b0, ADDR_W'(27'h200 + n), '0, 4'hF);
         end
      end
      checkOutput("fill_count", n, TAG_DEPTH);
      applyStimulus(1, 1'b0, 1'b1, 27'h300, 32'h1234_5678, 4'hF);
      m1_acc = 0; blocked = 0;
      for (int t = 0; t < 6; t++) begin
         endCycle();
         if (acc_id == 1) begin
            m1_acc++;
            applyStimulus(1, 1'b0, 1'b0, '0, '0, '0);
         end
         if (s_read || acc_id == 0) blocked++;
      end
      checkOutput("full_m1_write", m1_acc, 1);
      checkOutput("full_m0_stall", blocked, 0);
      respond(32'h55);
      checkOutput("full_rsp_m0", s_m0_rdv, 1'b1);
      checkOutput("full_rsp_data", s_m0_data, 32'h55);
      checkOutput("full_pop_noread", s_read, 1'b0);
      got = 0;
      for (int t = 0; t < 6 && got == 0; t++) begin
         endCycle();
         if (acc_id == 0) got = 1;
      end
      checkOutput("read9_accept", got, 1);
      applyStimulus(0, 1'b0, 1'b0, '0, '0, '0);
      for (int t = 0; t < 20 && exp_ids.size() > 0; t++) respond(DATA_W'(32'h100 + t));

      $display("[TB] interleaved read routing");
      issueCmd(0, 1'b1, 27'h10);
      issueCmd(1, 1'b1, 27'h20);
      issueCmd(0, 1'b1, 27'h30);
      respond(32'hA);
      checkOutput("ilv_m0_first", {s_m0_rdv, s_m1_rdv}, 2'b10);
      checkOutput("ilv_m0_data_a", s_m0_data, 32'hA);
      respond(32'hB);
      checkOutput("ilv_m1", {s_m0_rdv, s_m1_rdv}, 2'b01);
      checkOutput("ilv_m1_data_b", s_m1_data, 32'hB);
      respond(32'hC);
      checkOutput("ilv_m0_second", {s_m0_rdv, s_m1_rdv}, 2'b10);
      checkOutput("ilv_m0_data_c", s_m0_data, 32'hC);

      $display("[TB] randomized traffic");
      act[0] = 0; act[1] = 0; age[0] = 0; age[1] = 0; max_age = 0;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 2; i++) begin
            if (act[i] == 0 && $urandom_range(0, 9) < 4) begin
               kind = $urandom_range(0, 9);
               applyStimulus(i, (kind < 5) || (kind == 9), kind >= 5, ADDR_W'($urandom), $urandom,
                             BE_W'($urandom));
               act[i] = 1;
               age[i] = 0;
            end
         end
         mem_waitrequest_n = ($urandom_range(0, 3) != 0);
         if (exp_ids.size() > 0 && $urandom_range(0, 2) == 0) begin
            mem_readdatavalid = 1'b1;
            mem_readdata      = $urandom;
         end
         endCycle();
         mem_readdatavalid = 1'b0;
         for (int i = 0; i < 2; i++) begin
            if (act[i] != 0) begin
               if (acc_id == i) begin
                  act[i] = 0;
                  applyStimulus(i, 1'b0, 1'b0, '0, '0, '0);
               end else begin
                  age[i]++;
                  if (age[i] > max_age) max_age = age[i];
               end
            end
         end
      end
      checkOutput("bounded_wait", max_age <= 200, 1'b1);
      mem_waitrequest_n = 1'b1;
      for (int t = 0; t < 40 && exp_ids.size() > 0; t++) respond($urandom);

      $display("[TB] orphan response and async reset");
      checkOutput("rsp_error_clear", rsp_error, 1'b0);
      respond(32'hDEAD);
      checkOutput("orphan_strobes", {s_m0_rdv, s_m1_rdv}, 2'b00);
      checkOutput("rsp_error_set", rsp_error, 1'b1);
      mem_waitrequest_n = 1'b0;
      applyStimulus(0, 1'b0, 1'b1, 27'h777, 32'h7, 4'hF);
      endCycle();
      endCycle();
      checkOutput("stall_write", s_write, 1'b1);
      checkOutput("stall_no_begin", s_begin, 1'b0);
      #2;
      reset_reset = 1'b1;
      #1;
      checkOutput("arst_ready", arb_ready, 1'b0);
      checkOutput("arst_rsp_error", rsp_error, 1'b0);
      checkOutput("arst_mem_cmd", {mem_read, mem_write, mem_beginbursttransfer}, 3'b000);
      checkOutput("arst_ack", {m0_waitrequest_n, m1_waitrequest_n}, 2'b00);
      checkOutput("arst_burstcount", mem_burstcount, 1'b1);
      exp_ids.delete();
      prev_stall = 1'b0;
      local_init_done = 1'b0; local_cal_success = 1'b0;
      applyStimulus(0, 1'b0, 1'b0, '0, '0, '0);
      mem_waitrequest_n = 1'b1;
      @(posedge clk_clk); #1;
      reset_reset = 1'b0;

      $display("[TB] calibration failure");
      local_cal_fail = 1'b1;
      endCycle();
      local_cal_fail = 1'b0;
      checkOutput("calfail_error", cal_error, 1'b1);
      checkOutput("calfail_ready", arb_ready, 1'b0);
      local_init_done = 1'b1; local_cal_success = 1'b1;
      applyStimulus(0, 1'b0, 1'b1, 27'h55, 32'h5, 4'hF);
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         endCycle();
         if (s_ready || s_write || acc_id >= 0) bad++;
      end
      checkOutput("calfail_locked", bad, 0);
      checkOutput("calfail_sticky", cal_error, 1'b1);

      $display("[TB] %0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/lpddr2_avl_arbiter.md
Name: lpddr2_avl_arbiter

Overview:
Two-requester round-robin arbiter sharing the single LPDDR2 Avalon-MM controller port (27-bit word address, 32-bit data, single-beat bursts). It gates all traffic until the controller reports init done and calibration success. It routes read responses back to the issuing requester through an in-order tag FIFO. It sits between the user masters (m0, m1) and the LPDDR2 controller's avl_0 slave.

Parameters:
TAG_DEPTH, 8, max outstanding reads; power of 2, 2..32.
ADDR_W, 27, Avalon word address width.
DATA_W, 32, data width; byteenable is DATA_W/8.

Ports:
clk_clk  in  1  system clock; all logic on its rising edge.
reset_reset  in  1  asynchronous active-high reset.
m0_address / m1_address  in  ADDR_W  requester address.
m0_writedata / m1_writedata  in  DATA_W  write data.
m0_byteenable / m1_byteenable  in  DATA_W/8  byte lanes.
m0_read / m1_read  in  1  read request.
m0_write / m1_write  in  1  write request.
m0_waitrequest_n / m1_waitrequest_n  out  1  1 = command accepted this cycle.
m0_readdata / m1_readdata  out  DATA_W  read data.
m0_readdatavalid / m1_readdatavalid  out  1  response strobe.
mem_address  out  ADDR_W  to controller.
mem_writedata  out  DATA_W  to controller.
mem_byteenable  out  DATA_W/8  to controller.
mem_read  out  1  to controller.
mem_write  out  1  to controller.
mem_burstcount  out  1  constant 1.
mem_beginbursttransfer  out  1  first presentation cycle of each command.
mem_waitrequest_n  in  1  controller accept.
mem_readdata  in  DATA_W  controller read data.
mem_readdatavalid  in  1  controller response strobe.
local_init_done  in  1  controller status.
local_cal_success  in  1  controller status.
local_cal_fail  in  1  controller status.
arb_ready  out  1  1 = traffic enabled.
cal_error  out  1  sticky calibration failure.
rsp_error  out  1  sticky orphan response.

Behaviour:
- Reset: state = WAIT_CAL. All outputs 0 except mem_burstcount = 1. Grant pointer = m0. Tag FIFO empty. Error flags 0.
- FSM:
  - WAIT_CAL -> READY when init_done & cal_success both high in the same cycle.
  - WAIT_CAL -> FAIL when cal_fail is high; cal_fail takes priority if both are seen.
  - READY and FAIL have no exit except reset.
  - arb_ready = (state == READY), registered.
  - cal_error = 1 in FAIL.
- Outside READY: mem_read = mem_write = 0 and m*_waitrequest_n = 0. Requests are stalled, not dropped.
- A requester is eligible when (read | write) is high; reads additionally need tag FIFO not full.
- Grant is registered and locks while the granted requester holds an unaccepted command, per Avalon hold rules.
- On acceptance (mem_waitrequest_n & (mem_read | mem_write)):
  - Grant moves to the other requester if it is eligible next cycle; otherwise it stays.
  - If both are eligible, they alternate strictly.
- Granted requester's fields pass combinationally to mem_*. mem_waitrequest_n passes combinationally to the granted requester only; the non-granted requester sees 0.
- read & write both high from one requester: treated as write; read ignored.
- mem_beginbursttransfer = mem_read | mem_write on the first cycle of a new command presentation. It stays low on stall cycles that repeat the same command.
- Tag FIFO:
  - Push the grant ID on read acceptance. Pop on mem_readdatavalid.
  - Head ID selects which m*_readdatavalid pulses. mem_readdata fans out to both readdata ports unregistered. Zero added latency.
  - Full: reads are ineligible and that requester stalls; writes continue.
  - Simultaneous push and pop while full: the read is not accepted (full evaluated on registered count).
  - Simultaneous push and pop otherwise: count unchanged.
  - mem_readdatavalid while empty: no requester strobe; rsp_error set sticky.
- Reset mid-transaction: outstanding tags are discarded. Any late controller responses count as orphans after reset only if in READY.

Optional Feature:
ARB_PERF_CNT_EN
- Defined: adds outputs m0_cmd_count and m1_cmd_count (32 bits each) and stall_count (32 bits).
  - Command counters increment on each accepted command from that requester.
  - stall_count increments on each READY cycle in which some request is pending but nothing is accepted.
  - Counters wrap at 2^32 and clear on reset.
- Undefined: ports and counters are absent; behaviour otherwise identical.

Test Plan:
- Hold cal_success = 0 for 50 cycles with m0_write high -> no mem_write, m0_waitrequest_n = 0. Assert init_done & cal_success -> arb_ready = 1 next cycle, write issued with mem_beginbursttransfer = 1.
- Pulse cal_fail in WAIT_CAL -> cal_error = 1 and arb_ready = 0 permanently. A later cal_success is ignored.
- m0 and m1 both write continuously, mem_waitrequest_n = 1 -> mem_address alternates m0, m1, m0, ... One accept per cycle.
- m0 issues 8 reads (TAG_DEPTH = 8) with no responses -> 9th read stalls while an m1 write is accepted. One mem_readdatavalid -> m0 readdatavalid pulses, then the 9th read is accepted.
- Interleaved reads m0 (addr 0x10), m1 (0x20), m0 (0x30); controller returns 0xA, 0xB, 0xC -> m0 gets 0xA, 0xC; m1 gets 0xB.
- mem_readdatavalid with empty FIFO -> no requester strobe, rsp_error = 1. Assert reset_reset mid-stall -> all outputs return to reset values asynchronously.
